// File: rtl/rgy_light_monitor.sv
// Lamp-line observer: debounces {R,Y,G}, tracks phase order and dwell, latches the first fault.
// Define RGY_MON_SEG_EN to build the active-low 7-segment DWELL display on HEX0.
module rgy_light_monitor #(
    parameter int RED_SEC    = 4,
    parameter int YEL_SEC    = 1,
    parameter int GRN_SEC    = 4,
    parameter int TOL        = 1,
    parameter int GLITCH_CYC = 16
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       TICK,
    input  logic       CLR,
    input  logic       RED_IN,
    input  logic       YELLOW_IN,
    input  logic       GREEN_IN,
    output logic [2:0] STATE,
    output logic [3:0] DWELL,
    output logic [7:0] CYCLE_CNT,
    output logic       PHASE_DONE,
    output logic       ERR,
    output logic [2:0] ERR_CODE,
    output logic [6:0] HEX0
);
    localparam int CW = $clog2(GLITCH_CYC + 1);
    localparam logic [2:0] PAT_RED = 3'b100;
    localparam logic [2:0] PAT_YEL = 3'b010;
    localparam logic [2:0] PAT_GRN = 3'b001;

    typedef enum logic [2:0] {
        SYNC   = 3'd0,
        RED    = 3'd1,
        YELLOW = 3'd2,
        GREEN  = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t        state;
    logic [2:0]    lamps;
    logic [2:0]    samp;
    logic [2:0]    acc;
    logic [CW-1:0] cnt;
    logic [CW-1:0] next_cnt;
    logic          accept;
    logic          one_hot;
    logic          clear;
    logic          first_red;
    logic [3:0]    dwell;
    logic [7:0]    cycle_cnt;
    logic          phase_done;
    logic          err;
    logic [2:0]    err_code;
    logic [2:0]    succ_pat;
    int            exp_sec;

    assign lamps    = {RED_IN, YELLOW_IN, GREEN_IN};
    assign clear    = !RESET_N || CLR;
    assign next_cnt = (cnt != '0 && lamps == samp) ? cnt + CW'(1) : CW'(1);
    assign accept   = (lamps != acc) && (next_cnt == CW'(GLITCH_CYC));
    assign one_hot  = (lamps == PAT_RED) || (lamps == PAT_YEL) || (lamps == PAT_GRN);

    // The run length counts edges on which the live lamps match last cycle's registered sample.
    always_ff @(posedge CLK) begin
        if (clear) begin
            samp <= '0;
            acc  <= '0;
            cnt  <= '0;
        end else begin
            samp <= lamps;
            if (lamps == acc) begin
                cnt <= '0;
            end else if (accept) begin
                acc <= lamps;
                cnt <= '0;
            end else begin
                cnt <= next_cnt;
            end
        end
    end

    always_comb begin
        succ_pat = PAT_RED;
        exp_sec  = GRN_SEC;
        case (state)
            RED: begin
                succ_pat = PAT_YEL;
                exp_sec  = RED_SEC;
            end
            YELLOW: begin
                succ_pat = PAT_GRN;
                exp_sec  = YEL_SEC;
            end
            default: ;
        endcase
    end

    // An accept owns its edge: a coincident TICK is dropped, so it can never also report overstay.
    always_ff @(posedge CLK) begin
        if (clear) begin
            state      <= SYNC;
            dwell      <= '0;
            cycle_cnt  <= '0;
            phase_done <= 1'b0;
            err        <= 1'b0;
            err_code   <= '0;
            first_red  <= 1'b0;
        end else begin
            phase_done <= 1'b0;
            case (state)
                SYNC: begin
                    if (accept && lamps == PAT_RED) begin
                        state     <= RED;
                        dwell     <= '0;
                        first_red <= 1'b1;
                    end
                end
                RED, YELLOW, GREEN: begin
                    if (accept) begin
                        if (!one_hot) begin
                            state    <= FAULT;
                            err      <= 1'b1;
                            err_code <= 3'd1;
                        end else if (lamps != succ_pat) begin
                            state    <= FAULT;
                            err      <= 1'b1;
                            err_code <= 3'd2;
                        end else if (!(state == RED && first_red) && int'(dwell) < exp_sec - TOL) begin
                            state    <= FAULT;
                            err      <= 1'b1;
                            err_code <= 3'd3;
                        end else begin
                            if (state == GREEN) begin
                                cycle_cnt <= cycle_cnt + 8'd1;
                                state     <= RED;
                            end else if (state == RED) begin
                                state <= YELLOW;
                            end else begin
                                state <= GREEN;
                            end
                            dwell      <= '0;
                            phase_done <= 1'b1;
                            first_red  <= 1'b0;
                        end
                    end else if (TICK) begin
                        if (dwell != 4'd15) begin
                            dwell <= dwell + 4'd1;
                        end
                        if (int'(dwell) == exp_sec + TOL) begin
                            state    <= FAULT;
                            err      <= 1'b1;
                            err_code <= 3'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign STATE      = state;
    assign DWELL      = dwell;
    assign CYCLE_CNT  = cycle_cnt;
    assign PHASE_DONE = phase_done;
    assign ERR        = err;
    assign ERR_CODE   = err_code;

`ifdef RGY_MON_SEG_EN
    logic [6:0] hex;

    always_ff @(posedge CLK) begin
        if (clear) begin
            hex <= 7'b1111111;
        end else if (state == FAULT) begin
            hex <= 7'b0111111;
        end else begin
            case (dwell)
                4'd0:    hex <= 7'b1000000;
                4'd1:    hex <= 7'b1111001;
                4'd2:    hex <= 7'b0100100;
                4'd3:    hex <= 7'b0110000;
                4'd4:    hex <= 7'b0011001;
                4'd5:    hex <= 7'b0010010;
                4'd6:    hex <= 7'b0000010;
                4'd7:    hex <= 7'b1111000;
                4'd8:    hex <= 7'b0000000;
                4'd9:    hex <= 7'b0010000;
                default: hex <= 7'b0111111;
            endcase
        end
    end

    assign HEX0 = hex;
`else
    assign HEX0 = 7'b1111111;
`endif

endmodule
